store_narrower: RTL and testbench
=================================

Name: store_narrower

Overview:
- Store-side counterpart of the CPU's immediate/load widening path: narrows 32-bit register data into byte/halfword/word memory writes.
- Sits between the MEM-stage store request and the data-memory write port.
- Performs alignment checking, lane placement and byte-enable generation.
- Buffers accepted stores in a small FIFO drained over a valid/ready handshake.

Parameters:
- DEPTH, 4, store-buffer entries (power of two, >=2)
- CNT_W, 3, width of occupancy counter (log2(DEPTH)+1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  store request present
- req_ready  output  1  block can accept a request this cycle
- st_op  input  2  0=sw, 1=sh, 2=sb, 3=reserved
- addr  input  32  byte address of store
- wdata  input  32  register data (rt)
- mem_valid  output  1  head entry presented to memory
- mem_ready  input  1  memory accepts head entry
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  32  lane-placed write data
- mem_be  output  4  byte enables
- align_err  output  1  one-cycle pulse: rejected request
- err_addr  output  32  address of last rejected request
- count  output  CNT_W  current FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied; count=0; mem_valid=0; align_err=0; err_addr=0; mem_addr/mem_wdata/mem_be=0.
- req_ready = (count != DEPTH). No same-cycle full bypass: a pop in the same cycle does not raise req_ready.
- Accept: req_valid && req_ready at a rising edge.
- Alignment check on an accepted request:
  - sw requires addr[1:0]==0.
  - sh requires addr[0]==0.
  - sb is always aligned.
  - st_op==3 is always an error.
- Error path: request is not enqueued. align_err=1 for exactly the following cycle; err_addr latches addr. err_addr holds until the next error.
- Lane rules for aligned requests (computed at enqueue, stored per entry):
  - sw: be=4'b1111, data=wdata.
  - sh: data={wdata[15:0],wdata[15:0]}; be=4'b0011 if addr[1]==0, else 4'b1100.
  - sb: data=wdata[7:0] replicated to all four lanes; be=4'b0001<<addr[1:0].
- Output:
  - mem_valid = (count != 0).
  - mem_addr, mem_wdata and mem_be show the head entry; they are held stable while mem_valid && !mem_ready.
- Pop: mem_valid && mem_ready at a rising edge removes the head.
- Latency: request accepted at edge N is visible on mem_* in the cycle after edge N if the FIFO was empty. Otherwise it is visible after all older entries pop. Order is strictly FIFO.
- Simultaneous push and pop in the same edge: count unchanged; pointers both advance.
- Pop when empty and push when full cannot occur, because of the handshakes. Head and tail pointers wrap modulo DEPTH.
- Error and pop in the same cycle: pop proceeds normally; count decrements.
- mem_* outputs when the FIFO is empty: hold the last popped value. Consumers must qualify with mem_valid.
- Reset asserted mid-drain: all buffered stores are discarded immediately. No write is issued after reset release until a new request is accepted.

Test Plan:
- sb, addr=0x0000_1003, wdata=0x1234_56AB, mem_ready=1 -> next cycle: mem_valid=1, mem_addr=0x0000_1000, mem_wdata=0xABAB_ABAB, mem_be=4'b1000; count returns to 0 after pop.
- sh, addr=0x0000_2002, wdata=0xFFFF_BEEF -> mem_addr=0x0000_2000, mem_wdata=0xBEEF_BEEF, mem_be=4'b1100.
- sw, addr=0x0000_3001 -> align_err pulses 1 cycle; err_addr=0x0000_3001; count stays 0; mem_valid stays 0. Also sh at 0x...3 and st_op=3 both error.
- Hold mem_ready=0 and push 4 sw (0x10,0x14,0x18,0x1C) -> count=4, req_ready=0, head stable at 0x10. Release mem_ready -> drains in order 0x10,0x14,0x18,0x1C at one per cycle.
- Steady state at count=2 with push+pop every cycle for 10 cycles -> count stays 2; pointers wrap; output order matches input order.
- Fill 3 entries, pull reset low mid-drain -> count=0, mem_valid=0 asynchronously. After release, no mem_valid until a new push.

Source files
------------

// File: rtl/store_narrower.sv
// Store-side narrowing path: alignment check, lane placement and byte-enable
// generation, with accepted stores buffered in a small FIFO toward data memory.
module store_narrower #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       st_op,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic             align_err,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic             align_err_q, align_err_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic [29:0]      last_addr_q, last_addr_d;
  logic [31:0]      last_wdata_q, last_wdata_d;
  logic [3:0]       last_be_q, last_be_d;

  logic [29:0]      ent_addr_q  [DEPTH];
  logic [31:0]      ent_wdata_q [DEPTH];
  logic [3:0]       ent_be_q    [DEPTH];

  logic        aligned, accept, push, pop;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;

  always_comb begin
    aligned   = 1'b0;
    lane_data = wdata;
    lane_be   = 4'b0000;
    case (st_op)
      2'd0: begin
        aligned   = (addr[1:0] == 2'b00);
        lane_data = wdata;
        lane_be   = 4'b1111;
      end
      2'd1: begin
        aligned   = ~addr[0];
        lane_data = {2{wdata[15:0]}};
        lane_be   = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        aligned   = 1'b1;
        lane_data = {4{wdata[7:0]}};
        lane_be   = 4'b0001 << addr[1:0];
      end
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = (count_q != FULL);
    mem_valid = (count_q != '0);
    accept    = req_valid && req_ready;
    push      = accept && aligned;
    pop       = mem_valid && mem_ready;

    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    align_err_d  = accept && !aligned;
    err_addr_d   = err_addr_q;
    last_addr_d  = last_addr_q;
    last_wdata_d = last_wdata_q;
    last_be_d    = last_be_q;

    if (accept && !aligned) err_addr_d = addr;
    if (push) tail_d = tail_q + 1'b1;
    if (pop) begin
      head_d       = head_q + 1'b1;
      last_addr_d  = ent_addr_q[head_q];
      last_wdata_d = ent_wdata_q[head_q];
      last_be_d    = ent_be_q[head_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      align_err_q  <= 1'b0;
      err_addr_q   <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      last_be_q    <= '0;
    end else begin
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      align_err_q  <= align_err_d;
      err_addr_q   <= err_addr_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
      last_be_q    <= last_be_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q]  <= addr[31:2];
      ent_wdata_q[tail_q] <= lane_data;
      ent_be_q[tail_q]    <= lane_be;
    end
  end

  // When empty, present the most recently popped store rather than a stale slot.
  always_comb begin
    if (mem_valid) begin
      mem_addr  = {ent_addr_q[head_q], 2'b00};
      mem_wdata = ent_wdata_q[head_q];
      mem_be    = ent_be_q[head_q];
    end else begin
      mem_addr  = {last_addr_q, 2'b00};
      mem_wdata = last_wdata_q;
      mem_be    = last_be_q;
    end
  end

  assign align_err = align_err_q;
  assign err_addr  = err_addr_q;
  assign count     = count_q;

endmodule

// File: tb/tb_store_narrower.sv
// Directed self-checking bench for store_narrower.
module tb_store_narrower;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  st_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        align_err;
  logic [31:0] err_addr;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  store_narrower #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .st_op(st_op), .addr(addr), .wdata(wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .align_err(align_err), .err_addr(err_addr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    st_op     = op;
    addr      = a;
    wdata     = d;
  endtask

  task automatic push1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, op, a, d);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    mem_ready = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_align_err", 32'(align_err), 32'd0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    step();

    // sb at offset 3
    push1(2'd2, 32'h0000_1003, 32'h1234_56AB);
    chk("sb3_valid", 32'(mem_valid), 32'd1);
    chk("sb3_addr", mem_addr, 32'h0000_1000);
    chk("sb3_data", mem_wdata, 32'hABAB_ABAB);
    chk("sb3_be", 32'(mem_be), 32'h8);
    chk("sb3_count", 32'(count), 32'd1);
    step();
    chk("sb3_popped_count", 32'(count), 32'd0);
    chk("sb3_popped_valid", 32'(mem_valid), 32'd0);
    chk("sb3_hold_addr", mem_addr, 32'h0000_1000);
    chk("sb3_hold_data", mem_wdata, 32'hABAB_ABAB);

    // sb at offset 1
    push1(2'd2, 32'h0000_1001, 32'h0000_00CD);
    chk("sb1_data", mem_wdata, 32'hCDCD_CDCD);
    chk("sb1_be", 32'(mem_be), 32'h2);
    step();

    // sh upper half
    push1(2'd1, 32'h0000_2002, 32'hFFFF_BEEF);
    chk("sh2_addr", mem_addr, 32'h0000_2000);
    chk("sh2_data", mem_wdata, 32'hBEEF_BEEF);
    chk("sh2_be", 32'(mem_be), 32'hC);
    step();

    // sh lower half
    push1(2'd1, 32'h0000_2000, 32'h0000_1234);
    chk("sh0_data", mem_wdata, 32'h1234_1234);
    chk("sh0_be", 32'(mem_be), 32'h3);
    step();

    // sw aligned
    push1(2'd0, 32'h0000_5000, 32'hDEAD_BEEF);
    chk("sw_addr", mem_addr, 32'h0000_5000);
    chk("sw_data", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_be", 32'(mem_be), 32'hF);
    step();

    // misaligned sw
    push1(2'd0, 32'h0000_3001, 32'h1111_1111);
    chk("sw_err_pulse", 32'(align_err), 32'd1);
    chk("sw_err_addr", err_addr, 32'h0000_3001);
    chk("sw_err_count", 32'(count), 32'd0);
    chk("sw_err_valid", 32'(mem_valid), 32'd0);
    step();
    chk("sw_err_pulse_end", 32'(align_err), 32'd0);
    chk("sw_err_addr_hold", err_addr, 32'h0000_3001);

    // misaligned sh, then reserved op at an aligned address
    push1(2'd1, 32'h0000_3003, 32'h2222_2222);
    chk("sh_err_pulse", 32'(align_err), 32'd1);
    chk("sh_err_addr", err_addr, 32'h0000_3003);
    push1(2'd3, 32'h0000_4000, 32'h3333_3333);
    chk("op3_err_pulse", 32'(align_err), 32'd1);
    chk("op3_err_addr", err_addr, 32'h0000_4000);
    chk("op3_err_count", 32'(count), 32'd0);
    step();

    // fill with memory stalled
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push1(2'd0, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_head", mem_addr, 32'h10);
    push1(2'd0, 32'h20, 32'hEE);
    chk("full_reject_count", 32'(count), 32'd4);
    chk("full_head_stable", mem_addr, 32'h10);
    chk("full_head_data", mem_wdata, 32'hA0);

    // pop while full with a request pending: no bypass
    mem_ready = 1'b1;
    push1(2'd0, 32'h20, 32'hEE);
    chk("nobypass_count", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("drain_addr", mem_addr, 32'h10 + 32'(4 * i));
      chk("drain_data", mem_wdata, 32'hA0 + 32'(i));
      chk("drain_count", 32'(count), 32'(4 - i));
      step();
    end
    chk("drain_empty", 32'(mem_valid), 32'd0);

    // error and pop in the same cycle
    mem_ready = 1'b0;
    push1(2'd0, 32'h40, 32'h44);
    mem_ready = 1'b1;
    push1(2'd0, 32'h41, 32'h55);
    chk("errpop_count", 32'(count), 32'd0);
    chk("errpop_pulse", 32'(align_err), 32'd1);
    chk("errpop_addr", err_addr, 32'h41);
    chk("errpop_last", mem_addr, 32'h40);

    // steady state at two entries
    mem_ready = 1'b0;
    push1(2'd0, 32'h100, 32'h100 ^ 32'h5555_5555);
    push1(2'd0, 32'h104, 32'h104 ^ 32'h5555_5555);
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("ss_head_addr", mem_addr, 32'h100 + 32'(4 * k));
      chk("ss_head_data", mem_wdata, (32'h100 + 32'(4 * k)) ^ 32'h5555_5555);
      drive(1'b1, 2'd0, 32'h108 + 32'(4 * k), (32'h108 + 32'(4 * k)) ^ 32'h5555_5555);
      step();
      chk("ss_count", 32'(count), 32'd2);
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    chk("ss_tail0", mem_addr, 32'h128);
    step();
    chk("ss_tail1", mem_addr, 32'h12C);
    chk("ss_tail1_data", mem_wdata, 32'h12C ^ 32'h5555_5555);
    step();
    chk("ss_done", 32'(count), 32'd0);

    // reset mid-drain
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push1(2'd0, 32'h200 + 32'(4 * i), 32'(i));
    chk("pre_rst_count", 32'(count), 32'd3);
    mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(mem_valid), 32'd0);
    step();
    reset = 1'b1;
    step(); step(); step();
    chk("post_rst_valid", 32'(mem_valid), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    push1(2'd2, 32'h0000_0302, 32'h0000_0077);
    chk("post_rst_push_valid", 32'(mem_valid), 32'd1);
    chk("post_rst_push_addr", mem_addr, 32'h300);
    chk("post_rst_push_be", 32'(mem_be), 32'h4);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
